// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and default clocking.
package uart_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_CLK_FREQ_HZ   = 50_000_000;
  localparam int UART_BAUD_RATE     = 115_200;
  localparam int UART_CLKS_PER_BIT  = UART_CLK_FREQ_HZ / UART_BAUD_RATE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-facing bundle: serial line in, byte holding register and status pulses out.
interface uart_rx_if;

  logic                                rx;
  logic [uart_pkg::UART_DATA_BITS-1:0] data;
  logic                                valid;
  logic                                ready;
  logic                                frame_err;
  logic                                overrun;

  modport master (
    input  rx,
    input  ready,
    output data,
    output valid,
    output frame_err,
    output overrun
  );

  modport slave (
    output rx,
    output ready,
    input  data,
    input  valid,
    input  frame_err,
    input  overrun
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit with a selectable reset value.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture; the first stage may go metastable, the second gives it a cycle to settle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_r <= RESET_VALUE;
      sync_r <= RESET_VALUE;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a single-entry valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic      clock,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int DW    = UART_DATA_BITS;

  logic            rx_s;
  rx_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]      bit_idx_r, bit_idx_s;
  logic [DW-1:0]   shift_r, shift_s;
  logic            half_hit_s;
  logic            full_hit_s;
  logic            complete_s;
  logic            stop_bad_s;
  logic            accept_s;
  logic [DW-1:0]   data_r;
  logic            valid_r;
  logic            frame_err_r;
  logic            overrun_r;

  // Idle-high line, so the synchronizer must come out of reset reading 1.
  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  assign half_hit_s = (cnt_r == CNT_W'(HALF - 1));
  assign full_hit_s = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));
  assign accept_s   = valid_r & bus.ready;

  // FSM, bit-period counter, bit index and shift register state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
    end
  end

  // Next-state logic; the counter restarts at every sample point so samples stay mid-bit.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r + CNT_W'(1);
    bit_idx_s  = bit_idx_r;
    shift_s    = shift_r;
    complete_s = 1'b0;
    stop_bad_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        if (!rx_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (half_hit_s) begin
          cnt_s = '0;
          if (rx_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s   = ST_DATA;
            bit_idx_s = 3'd0;
          end
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (full_hit_s) begin
          cnt_s   = '0;
          shift_s = {rx_s, shift_r[DW-1:1]};
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (full_hit_s) begin
          cnt_s = '0;
          if (rx_s) begin
            complete_s = 1'b1;
            state_s    = ST_IDLE;
          end else begin
            stop_bad_s = 1'b1;
            state_s    = ST_BREAK;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        // A line held low must return high before another start bit is accepted.
        cnt_s = '0;
        if (rx_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        cnt_s   = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Holding register and status pulses; a completion may refill a slot emptied in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_r      <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= stop_bad_s;
      overrun_r   <= 1'b0;
      if (complete_s) begin
        if (!valid_r || bus.ready) begin
          data_r  <= shift_r;
          valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (accept_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign bus.data      = data_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: reset, single byte, glitch, framing, overrun, mid-frame reset.
module tb_uart_rx;

  localparam int CPB = 16;
  // Pin edge to valid: 2 sync cycles + HALF(8) + 9*16 + 1 = 155 cycles.
  localparam int LAT = 155;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int       cyc = 0;
  int       valid_cycles = 0;
  int       valid_rises = 0;
  int       rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  int       ferr_cnt = 0;
  int       ferr_cyc = 0;
  int       ovr_cnt = 0;
  int       ovr_cyc = 0;
  logic     prev_valid = 1'b0;

  always @(negedge clock) begin
    cyc        <= cyc + 1;
    prev_valid <= bus.valid;
    if (bus.valid) valid_cycles <= valid_cycles + 1;
    if (bus.valid && !prev_valid) begin
      valid_rises <= valid_rises + 1;
      rise_cyc    <= cyc + 1;
      rise_data   <= bus.data;
    end
    if (bus.frame_err) begin
      ferr_cnt <= ferr_cnt + 1;
      ferr_cyc <= cyc + 1;
    end
    if (bus.overrun) begin
      ovr_cnt <= ovr_cnt + 1;
      ovr_cyc <= cyc + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start);
    bus.rx = 1'b0;
    start = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      tick(CPB);
    end
    bus.rx = stop_bit;
    tick(CPB);
  endtask

  task automatic test_reset();
    int r0, f0, o0;
    bus.rx = 1'b1;
    bus.ready = 1'b0;
    reset = 1'b1;
    tick(5);
    checks++; if (bus.data !== 8'h00) begin failures++; $display("FAIL reset_data: got %02h want 00", bus.data); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b want 0", bus.overrun); end
    reset = 1'b0;
    r0 = valid_rises; f0 = ferr_cnt; o0 = ovr_cnt;
    tick(100);
    checks++; if (valid_rises - r0 !== 0) begin failures++; $display("FAIL idle_valid: got %0d rises want 0", valid_rises - r0); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL idle_ferr: got %0d want 0", ferr_cnt - f0); end
    checks++; if (ovr_cnt - o0 !== 0) begin failures++; $display("FAIL idle_ovr: got %0d want 0", ovr_cnt - o0); end
    checks++; if (bus.data !== 8'h00) begin failures++; $display("FAIL idle_data: got %02h want 00", bus.data); end
  endtask

  task automatic test_single_byte();
    int st, vc0, r0;
    bus.ready = 1'b1;
    vc0 = valid_cycles; r0 = valid_rises;
    send_frame(8'hA5, 1'b1, st);
    tick(10);
    checks++; if (rise_data !== 8'hA5) begin failures++; $display("FAIL single_data: got %02h want a5", rise_data); end
    checks++; if (rise_cyc - st !== LAT) begin failures++; $display("FAIL single_latency: got %0d want %0d", rise_cyc - st, LAT); end
    checks++; if (valid_cycles - vc0 !== 1) begin failures++; $display("FAIL single_width: got %0d cycles want 1", valid_cycles - vc0); end
    checks++; if (valid_rises - r0 !== 1) begin failures++; $display("FAIL single_rises: got %0d want 1", valid_rises - r0); end
  endtask

  task automatic test_glitch();
    int st, r0, f0, o0;
    r0 = valid_rises; f0 = ferr_cnt; o0 = ovr_cnt;
    bus.rx = 1'b0;
    tick(4);
    bus.rx = 1'b1;
    tick(30);
    checks++; if (valid_rises - r0 !== 0) begin failures++; $display("FAIL glitch_valid: got %0d rises want 0", valid_rises - r0); end
    checks++; if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin failures++; $display("FAIL glitch_flags: got %0d want 0", (ferr_cnt - f0) + (ovr_cnt - o0)); end
    send_frame(8'h3C, 1'b1, st);
    tick(10);
    checks++; if (rise_data !== 8'h3C) begin failures++; $display("FAIL glitch_next_data: got %02h want 3c", rise_data); end
    checks++; if (rise_cyc - st !== LAT) begin failures++; $display("FAIL glitch_next_latency: got %0d want %0d", rise_cyc - st, LAT); end
  endtask

  task automatic test_framing();
    int st, r0, f0;
    r0 = valid_rises; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, st);
    tick(40);
    bus.rx = 1'b1;
    tick(20);
    checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL frame_err_count: got %0d want 1", ferr_cnt - f0); end
    checks++; if (ferr_cyc - st !== LAT) begin failures++; $display("FAIL frame_err_time: got %0d want %0d", ferr_cyc - st, LAT); end
    checks++; if (valid_rises - r0 !== 0) begin failures++; $display("FAIL frame_no_valid: got %0d rises want 0", valid_rises - r0); end
    send_frame(8'h81, 1'b1, st);
    tick(10);
    checks++; if (rise_data !== 8'h81) begin failures++; $display("FAIL frame_next_data: got %02h want 81", rise_data); end
    checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL frame_next_ferr: got %0d want 1", ferr_cnt - f0); end
  endtask

  task automatic test_overrun();
    int st1, st2, r0, o0, f0;
    bus.ready = 1'b0;
    r0 = valid_rises; o0 = ovr_cnt; f0 = ferr_cnt;
    send_frame(8'h11, 1'b1, st1);
    send_frame(8'h22, 1'b1, st2);
    tick(10);
    checks++; if (bus.valid !== 1'b1) begin failures++; $display("FAIL ovr_valid: got %b want 1", bus.valid); end
    checks++; if (bus.data !== 8'h11) begin failures++; $display("FAIL ovr_data: got %02h want 11", bus.data); end
    checks++; if (valid_rises - r0 !== 1) begin failures++; $display("FAIL ovr_rises: got %0d want 1", valid_rises - r0); end
    checks++; if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt - o0); end
    checks++; if (ovr_cyc - st2 !== LAT) begin failures++; $display("FAIL ovr_time: got %0d want %0d", ovr_cyc - st2, LAT); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL ovr_ferr: got %0d want 0", ferr_cnt - f0); end
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL ovr_accept: got %b want 0", bus.valid); end
  endtask

  task automatic test_midframe_reset();
    int st, f0, o0;
    logic [7:0] b;
    b = 8'h5A;
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      bus.rx = b[i];
      tick(CPB);
    end
    bus.rx = b[3];
    tick(8);
    reset = 1'b1;
    #2;
    checks++; if (bus.data !== 8'h00) begin failures++; $display("FAIL mid_reset_data: got %02h want 00", bus.data); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b want 0", bus.valid); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL mid_reset_ferr: got %b want 0", bus.frame_err); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL mid_reset_ovr: got %b want 0", bus.overrun); end
    bus.rx = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(20);
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hC3, 1'b1, st);
    tick(10);
    checks++; if (bus.valid !== 1'b1 || bus.data !== 8'hC3) begin failures++; $display("FAIL mid_next_data: got v=%b d=%02h want v=1 d=c3", bus.valid, bus.data); end
    checks++; if (rise_cyc - st !== LAT) begin failures++; $display("FAIL mid_next_latency: got %0d want %0d", rise_cyc - st, LAT); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL mid_next_ferr: got %0d want 0", ferr_cnt - f0); end
    checks++; if (ovr_cnt - o0 !== 0) begin failures++; $display("FAIL mid_next_ovr: got %0d want 0", ovr_cnt - o0); end
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.ready = 1'b0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing();
    test_overrun();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for the Core's `io_rx` line: recovers 8N1 frames from an asynchronous pin, oversampling with a bit-period counter. It is the receiving counterpart of the Core's transmitter on `io_tx`. Received bytes are presented through a single-entry valid/ready holding register. Framing errors and overruns are flagged as one-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200). Minimum 8.
- `clock` in 1: the only clock; all state is on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `rx` in 1: serial line, asynchronous to `clock`, idle high.
- `data` out 8: received byte, valid while `valid`=1.
- `valid` out 1: holding register full.
- `ready` in 1: consumer accepts `data` when `valid && ready`.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a frame completes while the holding register is full.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. The synchronizer flops reset to 1.
- HALF = CLKS_PER_BIT/2 (integer division). The bit counter is wide enough for CLKS_PER_BIT-1.
- FSM states:
  - IDLE: on `rx_s`=0, go to START and clear the counter.
  - START: at the half-bit point, sample `rx_s`.
    - If 1 (glitch), return to IDLE with no flags.
    - If 0, go to DATA, bit index 0.
  - DATA: sample 8 bits, one per CLKS_PER_BIT, LSB first, shifting into a shift register. After bit 7, go to STOP.
  - STOP: sample `rx_s` one bit period after bit 7.
    - If 1, complete the frame and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Frame completion:
  - If the holding register is empty, or is being emptied this cycle (`valid && ready`): load `data`, set `valid`.
  - Otherwise: keep the old `data`, drop the new byte, pulse `overrun`.
- `valid` clears on `valid && ready` when no completion occurs in the same cycle.
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, counter=0, shift register=0.
- Reset mid-frame aborts the frame. No flags are produced.

## Timing
- Pin to `rx_s` latency: 2 cycles.
- Let t0 be the first cycle `rx_s`=0 while the FSM is in IDLE.
  - Start sample at t0+HALF.
  - Data bit i (0..7) sampled at t0+HALF+(i+1)·CLKS_PER_BIT.
  - Stop sampled at t0+HALF+9·CLKS_PER_BIT.
  - `valid` rises, or `frame_err`/`overrun` pulses, at t0+HALF+9·CLKS_PER_BIT+1.
- After a good stop sample the FSM returns to IDLE immediately. A start bit directly following the stop bit's midpoint is detected, so back-to-back frames are supported.
- `ready` is a plain acceptance input; `data` may change only on the cycle after acceptance or a load.
- `frame_err` and `overrun` are registered and never both high in the same cycle.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - Constants `UART_DATA_BITS`=8 and the default clock/baud values, shared with the transmitter.
- Sub-module `sync_2ff`: the generic 2-flop synchronizer with a reset-value parameter, instantiated here with reset value 1.
- Everything else (FSM, counter, shift register, holding register) lives in `uart_rx`.

## Test plan
All cases use CLKS_PER_BIT=16, HALF=8.
- **Reset:** assert `reset` with `rx`=1 for 5 cycles → `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0. After release with `rx` idle for 100 cycles → no outputs change.
- **Single byte:** `ready`=1, drive frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) → `valid` high for exactly 1 cycle at t0+153 with `data`=0xA5.
- **Glitch:** `rx` low for 4 cycles then high → no `valid`, no flags, FSM back in IDLE. A following 0x3C frame is received correctly.
- **Framing:** frame 0x3C with stop bit 0, line held low for 40 more cycles then high → single `frame_err` pulse, no `valid`. The next frame 0x81 gives `valid` with `data`=0x81.
- **Overrun:** `ready`=0, frames 0x11 then 0x22 back-to-back → `valid`=1 with `data`=0x11 throughout, one `overrun` pulse at the second completion. Then `ready`=1 for one cycle → `valid` drops next cycle.
- **Mid-frame reset:** assert `reset` during bit 3 of 0x5A → all outputs cleared asynchronously. After release, a full frame 0xC3 is received correctly with no flags.
